// File: rtl/shift_sequencer.sv
// Iterative shift sequencer: drives an external combinational shifter up to stepMax
// positions per cycle until the requested total is reached, then holds the word for a valid/ready consumer.
module shift_sequencer #(
  parameter int width    = 8,
  parameter int amtWidth = 8,
  parameter int stepMax  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [width-1:0]          cmd_bits,
  input  logic [amtWidth-1:0]       cmd_amt,
  input  logic                      cmd_dir,
  output logic [width-1:0]          sh_bits,
  output logic [$clog2(width)-1:0]  sh_shift,
  output logic                      sh_dir,
  input  logic [width-1:0]          sh_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [width-1:0]          res_bits
);

  localparam int SW = $clog2(width);
  localparam logic [amtWidth-1:0] STEP_A  = amtWidth'(stepMax);
  localparam logic [amtWidth:0]   WIDTH_X = (amtWidth+1)'(width);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t                state_q, state_d;
  logic [width-1:0]      acc_q, acc_d;
  logic [amtWidth-1:0]   rem_q, rem_d;
  logic                  dir_q, dir_d;
  logic [amtWidth-1:0]   step;
  logic [amtWidth-1:0]   rem_nxt;

  // step is never larger than rem, so the subtraction cannot wrap
  assign step    = (rem_q < STEP_A) ? rem_q : STEP_A;
  assign rem_nxt = rem_q - step;

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_bits  = acc_q;
  assign sh_bits   = acc_q;
  assign sh_dir    = dir_q;
  assign sh_shift  = (state_q == STEP) ? step[SW-1:0] : '0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d = cmd_dir;
          if (cmd_amt == '0) begin
            acc_d   = cmd_bits;
            rem_d   = '0;
            state_d = DONE;
          end else if ({1'b0, cmd_amt} >= WIDTH_X) begin
            acc_d   = '0;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            acc_d   = cmd_bits;
            rem_d   = cmd_amt;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        acc_d = sh_result;
        rem_d = rem_nxt;
        if (rem_nxt == '0) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural shifter closing the loop.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_bits = '0;
  logic [7:0] cmd_amt = '0;
  logic       cmd_dir = 1'b0;
  logic [7:0] sh_bits;
  logic [2:0] sh_shift;
  logic       sh_dir;
  logic [7:0] sh_result;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_bits;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign sh_result = sh_dir ? (sh_bits >> sh_shift) : (sh_bits << sh_shift);

  shift_sequencer #(.width(8), .amtWidth(8), .stepMax(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bits(cmd_bits), .cmd_amt(cmd_amt), .cmd_dir(cmd_dir),
    .sh_bits(sh_bits), .sh_shift(sh_shift), .sh_dir(sh_dir), .sh_result(sh_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_bits(res_bits)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] b, input logic [7:0] a, input logic d);
    if (a >= 8) return 8'h00;
    return d ? (b >> a) : (b << a);
  endfunction

  function automatic int model_lat(input logic [7:0] a);
    if (a == 0 || a >= 8) return 1;
    return 1 + (int'(a) + 2) / 3;
  endfunction

  // Result port monitor: sampled mid-cycle, a valid&ready pair here completes at the next edge.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_result", {24'h0, res_bits}, 32'hDEAD);
      else chk("res_bits", {24'h0, res_bits}, {24'h0, exp_q.pop_front()});
    end
  end

  // Issue one command from IDLE, follow the pass sequence, optionally stall the result.
  task automatic run_cmd(input logic [7:0] b, input logic [7:0] a, input logic d, input int hold);
    int rem;
    int lat;
    int stp;
    logic [7:0] e;
    e = model(b, a, d);
    res_ready = (hold == 0);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_bits = b; cmd_amt = a; cmd_dir = d;
    tick();
    cmd_valid = 1'b0;
    cmd_dir = ~d;
    exp_q.push_back(e);
    rem = (a >= 8) ? 0 : int'(a);
    lat = 1;
    while (!res_valid && lat < 40) begin
      stp = (rem < 3) ? rem : 3;
      chk("sh_shift_step", sh_shift, stp);
      chk("cmd_ready_busy", cmd_ready, 0);
      rem -= stp;
      tick();
      lat++;
    end
    chk("latency", lat, model_lat(a));
    chk("sh_shift_done", sh_shift, 0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_bits", {24'h0, res_bits}, {24'h0, e});
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("cmd_ready_after", cmd_ready, 1);
    chk("res_valid_after", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_bits", res_bits, 0);
    chk("rst_sh_bits", sh_bits, 0);
    chk("rst_sh_shift", sh_shift, 0);
    chk("rst_sh_dir", sh_dir, 0);
    #10 rst = 1'b1;
    tick();

    run_cmd(8'hB5, 8'd3, 1'b0, 0);
    run_cmd(8'h81, 8'd7, 1'b1, 0);
    run_cmd(8'h5A, 8'd0, 1'b0, 0);
    run_cmd(8'hFF, 8'd8, 1'b0, 0);
    run_cmd(8'hFF, 8'd255, 1'b1, 0);
    run_cmd(8'h3C, 8'd4, 1'b1, 5);
    run_cmd(8'hC3, 8'd6, 1'b0, 3);

    // Second command held valid while busy must wait until IDLE is re-entered.
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_bits = 8'h81; cmd_amt = 8'd7; cmd_dir = 1'b1;
    tick();
    exp_q.push_back(model(8'h81, 8'd7, 1'b1));
    cmd_bits = 8'h11; cmd_amt = 8'd2; cmd_dir = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      chk("busy_ready_low", cmd_ready, 0);
      tick();
      lat++;
    end
    chk("busy_first_lat", lat, 4);
    chk("busy_ready_done", cmd_ready, 0);
    tick();
    chk("busy_idle_ready", cmd_ready, 1);
    chk("busy_not_taken", res_valid, 0);
    exp_q.push_back(model(8'h11, 8'd2, 1'b0));
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_second_lat", lat, 2);
    tick();
    chk("busy_back_idle", cmd_ready, 1);

    // Reset during the second STEP pass discards the command.
    cmd_valid = 1'b1; cmd_bits = 8'hFF; cmd_amt = 8'd6; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_in_step", cmd_ready, 0);
    chk("pre_rst_shift", sh_shift, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_acc", res_bits, 0);
    chk("mid_rst_sh_shift", sh_shift, 0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_res_valid", res_valid, 0);
    run_cmd(8'h01, 8'd1, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] rb;
      logic [7:0] ra;
      logic rd;
      rb = 8'($urandom_range(0, 255));
      ra = (i % 5 == 4) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      run_cmd(rb, ra, rd, i % 3);
    end

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream control stage for the generic left/right shifter pair. Accepts shift commands over a valid/ready handshake.
- Commands may request a total shift larger than one shifter pass may perform. The block drives the combinational shifter iteratively, capped at stepMax positions per cycle, and feeds each shifter result back as the next pass's input.
- Presents the final word on a valid/ready result port.
- Logical shifts only: zero fill in both directions.

Parameters:
- width, 8: data width; must match the shifter's width parameter; width >= 2.
- amtWidth, 8: width of the requested total shift amount.
- stepMax, 3: maximum shift per pass; 1 <= stepMax <= width-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_bits  in  width  word to shift.
- cmd_amt  in  amtWidth  total shift amount.
- cmd_dir  in  1  0 = left, 1 = right.
- sh_bits  out  width  to shifter iBits.
- sh_shift  out  clog2(width)  to shifter shift.
- sh_dir  out  1  selects left/right shifter result.
- sh_result  in  width  selected shifter oBits (combinational).
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_bits  out  width  shifted word.

Behaviour:
- Registers: state, acc (width), rem (amtWidth), dir.
- States: IDLE, STEP, DONE.
- While rst is low: state=IDLE, acc=0, rem=0, dir=0.
  - Outputs during and after reset: cmd_ready=1 (IDLE), res_valid=0, res_bits=0, sh_bits=0, sh_shift=0, sh_dir=0.
- Combinational outputs:
  - cmd_ready = (state==IDLE).
  - res_valid = (state==DONE).
  - res_bits = acc; sh_bits = acc; sh_dir = dir.
  - sh_shift = min(rem, stepMax) in STEP, 0 otherwise.
- IDLE, on cmd_valid&&cmd_ready:
  - Latch dir=cmd_dir.
  - cmd_amt==0: acc=cmd_bits, rem=0, go DONE.
  - cmd_amt>=width: acc=0, rem=0, go DONE (saturate; no passes).
  - Otherwise: acc=cmd_bits, rem=cmd_amt, go STEP.
- STEP, each edge:
  - acc <= sh_result; rem <= rem - min(rem, stepMax).
  - Go DONE when the new rem is 0, else stay in STEP.
- DONE:
  - Hold acc stable while res_ready=0.
  - On res_ready=1: go IDLE.
- Latency, measured from the acceptance edge to the first cycle res_valid is high:
  - 1 edge if cmd_amt==0 or cmd_amt>=width.
  - Otherwise 1 + ceil(cmd_amt/stepMax) edges.
- No overlap: cmd_ready=0 in STEP and DONE. cmd_valid in those states is ignored, and that command is not consumed.
- New commands are accepted only once IDLE is re-entered, one cycle after the result handshake. There is no same-cycle bypass.
- rem arithmetic is unsigned; it never underflows because the step is min(rem, stepMax).
- Reset asserted mid-STEP or mid-DONE: immediate return to reset values. The in-flight command and its result are discarded with no res_valid pulse.
- cmd_dir is sampled only at acceptance; changes afterwards have no effect.

Test Plan:
- Left, one pass: cmd 0xB5, amt 3, dir 0 -> one STEP cycle, sh_shift=3; res_valid rises 2 edges after acceptance; res_bits=0xA8.
- Right, multi-pass: cmd 0x81, amt 7, dir 1 -> sh_shift sequence 3,3,1; res_bits=0x01; res_valid 4 edges after acceptance.
- Boundaries:
  - amt 0 with cmd 0x5A -> res_bits=0x5A after 1 edge, sh_shift stays 0.
  - amt 8 or amt 255 with cmd 0xFF -> res_bits=0x00 after 1 edge.
- Backpressure and busy:
  - res_ready=0 for 5 cycles in DONE -> res_valid and res_bits stay stable.
  - A second cmd_valid held during STEP/DONE is not accepted until the cycle after the result handshake.
- Reset mid-operation: assert rst low during the second STEP of (0xFF, amt 6, left) -> cmd_ready=1, res_valid=0, acc=0 immediately; a following command 0x01, amt 1 -> res_bits=0x02.
